// File: rtl/uart_cmd_tx.sv
// uart_cmd_tx: serializes a 16-bit command as two 8N1 UART frames on TX,
// high byte first, with no idle gap between the two frames.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line idle (TX=1), waiting for an accepted snd_cmd
// TX_HI | sending the frame for hold[15:8]
// TX_LO | sending the frame for hold[7:0]; cmd_snt set when it ends
module uart_cmd_tx #(
    parameter int BAUD_DIV = 5208
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd_cmd,
    input  logic [15:0] cmd,
    output logic        busy,
    output logic        cmd_snt,
    output logic        TX
);

    // One extra code so the final stop bit can be stretched by a cycle (see baud_tc).
    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BAUD_HOLD = CW'(BAUD_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TX_HI = 2'd1,
        TX_LO = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [15:0]     hold;
    logic [7:0]      shifter;
    logic [CW-1:0]   baud_cnt;
    logic [3:0]      bit_idx;
    logic            accept;
    logic            last_stop;
    logic            baud_tc;
    logic            frame_end;
    logic            done;
    logic            data_bit;

    assign accept    = snd_cmd && !busy;
    // TX is registered, so the wire runs one cycle behind the counters. The
    // last stop bit is counted one cycle longer so that IDLE, busy and
    // cmd_snt change exactly when that stop bit finishes on the wire.
    assign last_stop = (state == TX_LO) && (bit_idx == 4'd9);
    assign baud_tc   = last_stop ? (baud_cnt == BAUD_HOLD) : (baud_cnt == BAUD_LAST);
    assign frame_end = baud_tc && (bit_idx == 4'd9);
    assign data_bit  = (bit_idx >= 4'd1) && (bit_idx <= 4'd8);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: byte sequencing on frame boundaries.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = TX_HI;
                end
            end
            TX_HI: begin
                if (frame_end) begin
                    state_nxt = TX_LO;
                end
            end
            TX_LO: begin
                if (frame_end) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command hold register, written only on an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= 16'h0000;
        end else if (accept) begin
            hold <= cmd;
        end
    end

    // Baud counter and bit index; both rest at zero outside a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_idx  <= 4'd0;
        end else if (state == IDLE) begin
            baud_cnt <= '0;
            bit_idx  <= 4'd0;
        end else if (baud_tc) begin
            baud_cnt <= '0;
            bit_idx  <= (bit_idx == 4'd9) ? 4'd0 : bit_idx + 4'd1;
        end else begin
            baud_cnt <= baud_cnt + CW'(1);
        end
    end

    // Shift register: loaded with the current byte as the start bit ends,
    // shifted right as each data bit ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shifter <= 8'h00;
        end else if ((state != IDLE) && baud_tc) begin
            if (bit_idx == 4'd0) begin
                shifter <= (state == TX_HI) ? hold[15:8] : hold[7:0];
            end else if (data_bit) begin
                shifter <= {1'b0, shifter[7:1]};
            end
        end
    end

    // Registered serial output: start 0, data LSB first, stop 1, idle 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            TX <= 1'b1;
        end else if (state == IDLE) begin
            TX <= 1'b1;
        end else if (bit_idx == 4'd0) begin
            TX <= 1'b0;
        end else if (data_bit) begin
            TX <= shifter[0];
        end else begin
            TX <= 1'b1;
        end
    end

    // Handshake flags: busy for the whole command, cmd_snt sticky until next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            cmd_snt <= 1'b0;
        end else if (accept) begin
            busy    <= 1'b1;
            cmd_snt <= 1'b0;
        end else if (done) begin
            busy    <= 1'b0;
            cmd_snt <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Testbench for uart_cmd_tx: directed and random commands checked by an
// independent 8N1 receiver model and a timing-level command model.
module tb_uart_cmd_tx;

    localparam int B        = 16;
    localparam int DONE_LAT = 1 + 20 * B;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snd_cmd = 1'b0;
    logic [15:0] cmd = 16'h0000;
    logic        busy;
    logic        cmd_snt;
    logic        TX;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] byte_q[$];
    int         start_q[$];
    int         frm_err = 0;
    logic [7:0] exp_q[$];
    int         edge_q[$];
    bit         edge_en = 1'b0;
    int         m_free = 0;
    int         m_acc = 0;

    uart_cmd_tx #(.BAUD_DIV(B)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .snd_cmd (snd_cmd),
        .cmd     (cmd),
        .busy    (busy),
        .cmd_snt (cmd_snt),
        .TX      (TX)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 8N1 receiver model: detect falling start edge, sample mid-bit.
    initial begin
        logic       prev;
        logic [7:0] b;
        int         s;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && TX === 1'b0) begin
                s = cyc;
                repeat (B / 2) @(negedge clk);
                if (TX !== 1'b0) frm_err++;
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge clk);
                    b[i] = TX;
                end
                repeat (B) @(negedge clk);
                if (TX !== 1'b1) frm_err++;
                byte_q.push_back(b);
                start_q.push_back(s);
            end
            prev = TX;
        end
    end

    // Line transition recorder for bit-period measurement.
    initial begin
        logic p;
        p = 1'b1;
        forever begin
            @(negedge clk);
            if (edge_en && TX !== p) edge_q.push_back(cyc);
            p = TX;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle request from a negedge; the model decides acceptance.
    task automatic send_req(input logic [15:0] v, output bit ok);
        int a;
        a = cyc + 1;
        snd_cmd = 1'b1;
        cmd = v;
        ok = (a >= m_free);
        if (ok) begin
            m_acc  = a;
            m_free = a + DONE_LAT + 1;
            exp_q.push_back(v[15:8]);
            exp_q.push_back(v[7:0]);
        end
        @(negedge clk);
        snd_cmd = 1'b0;
    endtask

    task automatic start_cmd(input string tag, input logic [15:0] v);
        bit ok;
        send_req(v, ok);
        check({tag, "_accept"}, ok, 1'b1);
        check({tag, "_busy_set"}, busy, 1'b1);
        check({tag, "_snt_clr"}, cmd_snt, 1'b0);
        @(negedge clk);
        check({tag, "_start_lat"}, TX, 1'b0);
    endtask

    task automatic finish_cmd(input string tag);
        int n;
        n = 0;
        while (cmd_snt !== 1'b1 && n < 2 * DONE_LAT) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_lat"}, cyc - m_acc, DONE_LAT);
        check({tag, "_busy_clr"}, busy, 1'b0);
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_nbytes"}, byte_q.size(), exp_q.size());
        while (exp_q.size() > 0 && byte_q.size() > 0)
            check({tag, "_byte"}, byte_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        byte_q.delete();
    endtask

    task automatic check_gap(input string tag);
        check({tag, "_nframes"}, start_q.size() % 2, 0);
        for (int i = 0; i + 1 < start_q.size(); i += 2)
            check({tag, "_nogap"}, start_q[i+1] - start_q[i], 10 * B);
        start_q.delete();
    endtask

    initial begin
        bit         ok;
        bit         idle_ok;
        logic [15:0] r;

        // 1. reset and idle line
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tx", TX, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_snt", cmd_snt, 1'b0);
        idle_ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (TX !== 1'b1) idle_ok = 1'b0;
        end
        check("idle_tx", idle_ok, 1'b1);

        // 2. basic send
        start_cmd("basic", 16'hA55A);
        finish_cmd("basic");
        check_bytes("basic");
        check_gap("basic");

        // 3. requests while busy are ignored
        start_cmd("busy", 16'h1234);
        while (cyc < m_acc + 49) @(negedge clk);
        send_req(16'hFFFF, ok);
        check("busy_ign50", ok, 1'b0);
        while (cyc < m_acc + 199) @(negedge clk);
        send_req(16'hFFFF, ok);
        check("busy_ign200", ok, 1'b0);
        finish_cmd("busy");
        check_bytes("busy");
        check_gap("busy");

        // 4. same-edge request ignored, then back-to-back accept
        start_cmd("b2b1", 16'h00FF);
        while (cyc < m_acc + DONE_LAT - 1) @(negedge clk);
        check("b2b_snt_early", cmd_snt, 1'b0);
        send_req(16'hDEAD, ok);
        check("b2b_same_edge_ign", ok, 1'b0);
        check("b2b_snt_rise", cmd_snt, 1'b1);
        check("b2b_busy_low", busy, 1'b0);
        start_cmd("b2b2", 16'h8001);
        finish_cmd("b2b2");
        check_bytes("b2b");
        check_gap("b2b");

        // 5. async reset in the middle of the high byte
        start_cmd("rst", 16'hE7E7);
        while (cyc < m_acc + 90) @(negedge clk);
        check("rst_pre_tx", TX, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_tx", TX, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_snt", cmd_snt, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_free = 0;
        repeat (200) @(negedge clk);
        check("rst_idle_tx", TX, 1'b1);
        exp_q.delete();
        byte_q.delete();
        start_q.delete();
        frm_err = 0;
        start_cmd("post_rst", 16'hC3C3);
        finish_cmd("post_rst");
        check_bytes("post_rst");
        check_gap("post_rst");

        // 6. every bit period on an alternating pattern
        edge_q.delete();
        edge_en = 1'b1;
        start_cmd("timing", 16'h5555);
        finish_cmd("timing");
        edge_en = 1'b0;
        check("timing_nedges", edge_q.size(), 20);
        if (edge_q.size() > 0) check("timing_first", edge_q[0] - m_acc, 1);
        for (int i = 1; i < edge_q.size(); i++)
            check("timing_period", edge_q[i] - edge_q[i-1], B);
        check_bytes("timing");
        check_gap("timing");

        // corner words and random commands
        for (int k = 0; k < 8; k++) begin
            if (k == 0)      r = 16'h0000;
            else if (k == 1) r = 16'hFFFF;
            else             r = 16'($urandom);
            start_cmd("rand", r);
            if (k % 2 == 0) begin
                while (cyc < m_acc + 1 + $urandom_range(1, 300)) @(negedge clk);
                cmd = ~r;
            end
            finish_cmd("rand");
            check_bytes("rand");
            check_gap("rand");
            repeat ($urandom_range(1, 5)) @(negedge clk);
        end

        check("frame_errors", frm_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
